// File: rtl/div_pkg.sv
// div_pkg: shared FSM states, width limits and two's-complement magnitude helper for divider_signed_seq
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int DIV_MIN_WIDTH = 4;
  localparam int DIV_MAX_WIDTH = 64;
  function automatic logic [DIV_MAX_WIDTH-1:0] mag(input logic [DIV_MAX_WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
endpackage

// File: rtl/divider_signed_seq_udiv_core.sv
// udiv_core: unsigned radix-2 shift-subtract engine, one quotient bit per step, borrow from a WIDTH+1 bit accumulator
module udiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             last
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic [WIDTH:0] acc, sh, diff;
  logic [WIDTH-1:0] q, d;
  logic [CNT_W-1:0] cnt;
  assign sh = (acc << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
  assign diff = sh - {1'b0, d};
  assign last = step && cnt == CNT_W'(WIDTH - 1);
  assign quo = q;
  assign rem = acc[WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      q <= dvd;
      d <= dvs;
      cnt <= '0;
    end else if (step) begin
      acc <= diff[WIDTH] ? sh : diff;
      q <= {q[WIDTH-2:0], ~diff[WIDTH]};
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/divider_signed_seq.sv
// divider_signed_seq: signed/unsigned sequential divider with start/done handshake; DIV_OVERFLOW_DETECT_EN flags signed MIN/-1 as error
module divider_signed_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             error,
  output logic             done,
  output logic             busy
);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  if (WIDTH < DIV_MIN_WIDTH || WIDTH > DIV_MAX_WIDTH) begin : g_bad_width
    $error("divider_signed_seq: unsupported WIDTH");
  end
  state_t state;
  logic neg_q, neg_r, accept, zero, ovf, last;
  logic [WIDTH-1:0] quo, rem, dvd_mag, dvs_mag;
  assign accept = state == IDLE && start;
  assign zero = divisor == '0;
`ifdef DIV_OVERFLOW_DETECT_EN
  assign ovf = signed_mode && dividend == MIN && divisor == '1;
`else
  assign ovf = 1'b0;
`endif
  assign dvd_mag = WIDTH'(mag(DIV_MAX_WIDTH'(dividend), signed_mode & dividend[WIDTH-1]));
  assign dvs_mag = WIDTH'(mag(DIV_MAX_WIDTH'(divisor), signed_mode & divisor[WIDTH-1]));
  assign busy = state != IDLE;
  assign done = state == DONE;
  udiv_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .reset(reset),
    .load (accept && !zero && !ovf),
    .step (state == CALC),
    .dvd  (dvd_mag),
    .dvs  (dvs_mag),
    .quo  (quo),
    .rem  (rem),
    .last (last)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      quotient <= '0;
      remainder <= '0;
      error <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          neg_q <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r <= signed_mode & dividend[WIDTH-1];
          if (zero || ovf) begin
            state <= DONE;
            quotient <= zero ? '1 : MIN;
            remainder <= zero ? dividend : '0;
            error <= 1'b1;
          end else begin
            state <= CALC;
          end
        end
        CALC: if (last) state <= FIX;
        FIX: begin
          state <= DONE;
          quotient <= neg_q ? -quo : quo;
          remainder <= neg_r ? -rem : rem;
          error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_signed_seq.sv
// tb_divider_signed_seq: directed and random checks of divider_signed_seq against a plain-arithmetic reference model
module tb_divider_signed_seq;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, signed_mode = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0, quotient, remainder;
  logic error, done, busy;
  int ncmp = 0, nfail = 0;
  divider_signed_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .error(error), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic e, output int lat);
    longint sa, sb;
    e = 1'b0;
    lat = W + 2;
    if (b == '0) begin
      q = '1;
      r = a;
      e = 1'b1;
      lat = 1;
    end else if (m) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
`ifdef DIV_OVERFLOW_DETECT_EN
      if (a == MIN && b == '1) begin
        e = 1'b1;
        lat = 1;
      end
`endif
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction
  task automatic run(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int hold, input int inject_at, output int lat, output logic bz_ok);
    @(negedge clk);
    signed_mode = m;
    dividend = a;
    divisor = b;
    start = 1'b1;
    lat = 0;
    bz_ok = 1'b1;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (hold == 0) start = 1'b0;
      if (inject_at != 0 && lat == inject_at) begin
        start = 1'b1;
        signed_mode = ~m;
        dividend = $urandom;
        divisor = $urandom | 32'd1;
      end
      if (inject_at != 0 && lat == inject_at + 1) start = 1'b0;
      if (busy !== 1'b1) bz_ok = 1'b0;
      if (done === 1'b1) break;
    end
  endtask
  task automatic do_op(input string tag, input logic m, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold, input int inject_at);
    logic [W-1:0] eq, er;
    logic ee, bz_ok;
    int elat, lat;
    model(m, a, b, eq, er, ee, elat);
    run(m, a, b, hold, inject_at, lat, bz_ok);
    chk({tag, "_latency"}, W'(lat), W'(elat));
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_error"}, W'(error), W'(ee));
    chk({tag, "_busy"}, W'(bz_ok), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, W'(done), 32'd0);
    chk({tag, "_idle"}, W'(busy), 32'd0);
  endtask
  initial begin
    logic any_done, m;
    logic [W-1:0] a, b;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quotient", quotient, '0);
    chk("rst_remainder", remainder, '0);
    chk("rst_error", W'(error), 32'd0);
    chk("rst_done", W'(done), 32'd0);
    chk("rst_busy", W'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("u_45234_101", 1'b0, 32'd45234, 32'd101, 0, 0);
    do_op("s_m45234_101", 1'b1, -32'd45234, 32'd101, 0, 0);
    do_op("s_7_m2", 1'b1, 32'd7, -32'd2, 0, 0);
    do_op("u_div0", 1'b0, 32'd1234, 32'd0, 0, 0);
    do_op("s_div0", 1'b1, 32'd1234, 32'd0, 0, 0);
    do_op("s_min_m1", 1'b1, MIN, 32'hFFFF_FFFF, 0, 0);
    do_op("u_min_m1", 1'b0, MIN, 32'hFFFF_FFFF, 0, 0);
    do_op("s_m7_m2", 1'b1, -32'd7, -32'd2, 0, 0);
    do_op("u_small_big", 1'b0, 32'd5, 32'd9, 0, 0);
    do_op("mid_calc_start", 1'b0, 32'd987654321, 32'd12345, 0, 5);
    do_op("hold_first", 1'b1, -32'd1000, 32'd7, 1, 0);
    @(posedge clk);
    #1;
    chk("hold_accept", W'(busy), 32'd1);
    start = 1'b0;
    n = 1;
    while (n < 200 && done !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_second_latency", W'(n), W'(W + 2));
    chk("hold_second_quotient", quotient, -32'd142);
    chk("hold_second_remainder", remainder, -32'd6);
    @(negedge clk);
    signed_mode = 1'b0;
    dividend = 32'hFFFF_FFFF;
    divisor = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_quotient", quotient, '0);
    chk("rst_mid_remainder", remainder, '0);
    chk("rst_mid_error", W'(error), 32'd0);
    chk("rst_mid_busy", W'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    any_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) any_done = 1'b1;
    end
    chk("rst_no_done", W'(any_done), 32'd0);
    do_op("after_rst_100_7", 1'b0, 32'd100, 32'd7, 0, 0);
    repeat (30) begin
      m = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? MIN : $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = $urandom_range(1, 15);
        2: b = -W'($urandom_range(1, 15));
        3: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      do_op("random", m, a, b, 0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
